// File: rtl/aes_pkg.sv
`default_nettype none
//==============================================================================
// aes_pkg : shared AES-256 key-schedule constants, types and GF(2^8) helpers
// Rev 1.0
//==============================================================================
package aes_pkg;

  localparam int aes_key_width_gp = 256;
  localparam int aes_rk_width_gp  = 128;
  localparam int aes256_num_rk_gp = 15;
  localparam int aes256_iter_gp   = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [0:aes_rk_width_gp-1]  rk_t;
  typedef logic [0:aes_key_width_gp-1] key_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (a^254, zero maps to zero) plus the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] pw;
    logic [7:0] inv;
    pw  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_schedule_if.sv
`default_nettype none
//==============================================================================
// aes_key_schedule_if : key handshake and round-key read port bundle
// Rev 1.0
//==============================================================================
interface aes_key_schedule_if;
  import aes_pkg::*;

  key_t       key_i;
  logic       v_i;
  logic       ready_o;
  logic [0:3] rk_addr_i;
  rk_t        rk_o;
  logic       keys_v_o;
  logic       busy_o;

  modport master (
    output key_i, v_i, rk_addr_i,
    input  ready_o, rk_o, keys_v_o, busy_o
  );

  modport slave (
    input  key_i, v_i, rk_addr_i,
    output ready_o, rk_o, keys_v_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/aes_key_schedule_round_key.sv
`default_nettype none
//==============================================================================
// round_key : one AES-256 expansion step, words 8(r-1)..8r-1 -> 8r..8r+7
// Rev 1.0
//==============================================================================
module round_key
  import aes_pkg::*;
(
  input  logic [0:255] k,
  input  logic [4:0]   r,
  output logic [0:255] result
);

  logic [31:0] w_word [8];
  logic [31:0] w_next [8];
  logic [31:0] w_temp;
  logic [7:0]  w_rcon;
  logic [0:255] w_result;

  always_comb begin
    w_rcon = 8'h01;
    for (int j = 2; j < 32; j++) begin
      if (5'(j) <= r) w_rcon = gf_mul(w_rcon, 8'h02);
    end
    for (int i = 0; i < 8; i++) w_word[i] = k[32*i +: 32];
    w_temp    = sub_word({w_word[7][23:0], w_word[7][31:24]}) ^ {w_rcon, 24'h000000};
    w_next[0] = w_word[0] ^ w_temp;
    for (int i = 1; i < 4; i++) w_next[i] = w_word[i] ^ w_next[i-1];
    // Second half of an AES-256 step applies SubWord without rotation or rcon
    w_next[4] = w_word[4] ^ sub_word(w_next[3]);
    for (int i = 5; i < 8; i++) w_next[i] = w_word[i] ^ w_next[i-1];
    w_result = '0;
    for (int i = 0; i < 8; i++) w_result[32*i +: 32] = w_next[i];
  end

  assign result = w_result;

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
//==============================================================================
// aes_key_schedule : AES-256 key expansion controller, 15-entry round-key buffer
// Rev 1.0
//==============================================================================
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int num_rk_p = 15,
  parameter int iter_p   = 7
) (
  input logic               clk_i,
  input logic               reset_i,
  aes_key_schedule_if.slave bus
);

  if (num_rk_p != aes256_num_rk_gp || iter_p != aes256_iter_gp) begin : g_param_check
    $error("aes_key_schedule: only num_rk_p=15 and iter_p=7 are supported");
  end

  state_t                    r_state;
  logic [2:0]                r_cnt;
  key_t                      r_work;
  rk_t [0:num_rk_p-1]        r_rk;
  logic                      r_ready;
  logic                      r_keys_v;
  logic                      r_busy;
  logic [0:255]              w_result;

  round_key u_round_key (
    .k      (r_work),
    .r      ({2'b00, r_cnt}),
    .result (w_result)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_work   <= '0;
      r_rk     <= '0;
      r_ready  <= 1'b1;
      r_keys_v <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.v_i && r_ready) begin
            r_rk[0]  <= bus.key_i[0:127];
            r_rk[1]  <= bus.key_i[128:255];
            r_work   <= bus.key_i;
            r_cnt    <= 3'd1;
            r_state  <= EXPAND;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_keys_v <= 1'b0;
          end
        end
        EXPAND: begin
          // Iteration r owns slots 2r and 2r+1; slot 15 does not exist, so the
          // upper half of the last result (w60..w63) is dropped.
          for (int i = 2; i < num_rk_p; i++) begin
            if (i[3:1] == r_cnt) r_rk[i] <= i[0] ? w_result[128:255] : w_result[0:127];
          end
          r_work <= w_result;
          if (r_cnt == 3'(iter_p)) begin
            r_state  <= DONE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_keys_v <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
          r_keys_v <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.rk_o = '0;
    if (bus.rk_addr_i < 4'(num_rk_p)) bus.rk_o = r_rk[bus.rk_addr_i];
  end

  assign bus.ready_o  = r_ready;
  assign bus.keys_v_o = r_keys_v;
  assign bus.busy_o   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tb_aes_key_schedule : scoreboard bench against a FIPS-197 word-loop model
// Rev 1.0
//==============================================================================
module tb_aes_key_schedule;

  typedef logic [0:14][127:0] rkset_t;
  typedef struct packed {
    rkset_t      rks;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cyc = '0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  logic [7:0]  sb [256];
  logic [3:0]  main_addr = 4'd0;
  logic [3:0]  mon_addr  = 4'd0;
  logic        mon_busy  = 1'b0;

  aes_key_schedule_if bus();

  aes_key_schedule #(.num_rk_p(15), .iter_p(7)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  assign bus.rk_addr_i = mon_busy ? mon_addr : main_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: ready_o did not rise within 40 cycles", name);
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  // Table built by walking generator 3 and its inverse, independent of the RTL
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic rkset_t model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rkset_t      res;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int j = 0; j < 15; j++) res[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic push(input logic [255:0] key);
    exp_t e;
    e.rks = model(key);
    e.acc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (bus.ready_o !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (bus.ready_o !== 1'b1) fail(name);
  endtask

  task automatic rd(input int a, input string name, input logic [127:0] exp);
    main_addr = 4'(a);
    #0.2;
    chk(name, bus.rk_o, exp);
  endtask

  // Entered at a negedge; returns at the negedge after expansion completes
  task automatic send(input logic [255:0] key, input bit noise);
    wait_ready("send wait");
    bus.key_i = key;
    bus.v_i   = 1'b1;
    push(key);
    @(negedge clk);
    bus.v_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) chk("keys_v drops after accept", bus.keys_v_o, 0);
      chk("ready low in expand", bus.ready_o, 0);
      chk("busy high in expand", bus.busy_o, 1);
      if (noise && i == 2) begin
        bus.key_i = rand256();
        bus.v_i   = 1'b1;
      end
      if (noise && i == 4) bus.v_i = 1'b0;
      @(negedge clk);
    end
    chk("ready back after expand", bus.ready_o, 1);
    chk("busy low after expand", bus.busy_o, 0);
  endtask

  // Monitor: each rising keys_v_o retires one expected key set
  initial begin : monitor
    logic prev_kv;
    exp_t e;
    prev_kv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.keys_v_o === 1'b1 && !prev_kv) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected keys_v rise: got 1, expected 0");
        end else begin
          e = exp_q.pop_front();
          chk("keys_v latency incl accept edge", cyc - e.acc + 1, 8);
          mon_busy = 1'b1;
          for (int a = 0; a < 15; a++) begin
            mon_addr = 4'(a);
            #0.2;
            chk($sformatf("rk%0d", a), bus.rk_o, e.rks[a]);
          end
          mon_busy = 1'b0;
        end
      end
      prev_kv = (bus.keys_v_o === 1'b1);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [255:0] fips;
    logic [255:0] k64;
    fips = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    k64  = {32{8'h64}};
    init_sbox();
    bus.key_i = '0;
    bus.v_i   = 1'b0;

    // Key presented during reset must not be accepted
    repeat (2) @(negedge clk);
    bus.key_i = fips;
    bus.v_i   = 1'b1;
    @(negedge clk);
    bus.v_i = 1'b0;
    chk("reset ready", bus.ready_o, 1);
    chk("reset keys_v", bus.keys_v_o, 0);
    chk("reset busy", bus.busy_o, 0);
    rd(0, "reset rk0", 0);
    rd(14, "reset rk14", 0);
    rst = 1'b0;
    @(negedge clk);

    send(fips, 1'b0);
    @(negedge clk);
    rd(0,  "fips rk0",  128'h603deb1015ca71be2b73aef0857d7781);
    rd(1,  "fips rk1",  128'h1f352c073b6108d72d9810a30914dff4);
    rd(2,  "fips rk2",  128'h9ba354118e6925afa51a8b5f2067fcde);
    rd(3,  "fips rk3",  128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    rd(14, "fips rk14", 128'hfe4890d1e6188d0b046df344706c631e);

    send(k64, 1'b0);
    @(negedge clk);
    rd(0, "k64 rk0", {16{8'h64}});
    rd(1, "k64 rk1", {16{8'h64}});

    // Second key offered mid-expansion is ignored
    send(fips, 1'b1);
    @(negedge clk);
    rd(14, "noise rk14", 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset three edges after accepting a key
    bus.key_i = rand256();
    bus.v_i   = 1'b1;
    @(negedge clk);
    bus.v_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset ready", bus.ready_o, 1);
    chk("midreset keys_v", bus.keys_v_o, 0);
    chk("midreset busy", bus.busy_o, 0);
    for (int a = 0; a < 16; a++) rd(a, $sformatf("midreset rk%0d", a), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midreset keys_v stays low", bus.keys_v_o, 0);

    for (int n = 0; n < 4; n++) send(rand256(), 1'b0);
    @(negedge clk);
    rd(15, "addr15 reads zero", 0);

    // Back-to-back with v_i held high
    wait_ready("b2b wait");
    bus.key_i = rand256();
    bus.v_i   = 1'b1;
    for (int c = 0; c < 24; c++) begin
      chk($sformatf("b2b ready c%0d", c), bus.ready_o, (c % 8 == 0));
      if (c % 8 == 0) push(bus.key_i);
      @(posedge clk);
      #1;
      if (c % 8 == 0) bus.key_i = rand256();
      @(negedge clk);
    end
    bus.v_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
